// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types for the multi-port register file.
//   sweep_state_e - clear/dump engine states. The encodings are fixed because
//                   the debug unit decodes them.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DUMP  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between the register file and its users.
//   ra/rd                  : NRD packed read ports (port i at ra[i*AW +: AW],
//                            rd[i*WIDTH +: WIDTH])
//   we0/wa0/wd0            : write port 0
//   we1/wa1/wd1            : write port 1 (wins over port 0 on the same entry)
//   clr_req/dump_req       : sweep engine requests
//   busy                   : engine active
//   dump_valid/addr/data   : registered dump stream for the debug unit
// The master modport is the user side; the slave modport is the register file.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);

  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic                 we0;
  logic [AW-1:0]        wa0;
  logic [WIDTH-1:0]     wd0;
  logic                 we1;
  logic [AW-1:0]        wa1;
  logic [WIDTH-1:0]     wd1;
  logic                 clr_req;
  logic                 dump_req;
  logic                 busy;
  logic                 dump_valid;
  logic [AW-1:0]        dump_addr;
  logic [WIDTH-1:0]     dump_data;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, clr_req, dump_req,
    input  rd, busy, dump_valid, dump_addr, dump_data
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, clr_req, dump_req,
    output rd, busy, dump_valid, dump_addr, dump_data
  );

endinterface

// File: rtl/regfile_mp_sweep_ctrl.sv
// rf_sweep_ctrl: clear/dump sweep engine for regfile_mp.
//   clk, rst_n         : clock, asynchronous active-low reset
//   clr_req, dump_req  : start requests, only looked at in IDLE (clear wins)
//   state              : current engine state
//   idx                : entry being cleared/dumped this cycle
//   busy               : state != IDLE
// A sweep visits entries 0..DEPTH-1, one per cycle, then returns to IDLE.
// Requests that arrive while a sweep is running are dropped.
module rf_sweep_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          dump_req,
  output sweep_state_e  state,
  output logic [AW-1:0] idx,
  output logic          busy
);

  // DEPTH-1 is all ones, so the increment wraps back to 0 on the last entry.
  localparam logic [AW-1:0] LAST = '1;

  sweep_state_e  state_nxt;
  logic [AW-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        if (clr_req)       state_nxt = ST_CLEAR;
        else if (dump_req) state_nxt = ST_DUMP;
      end
      ST_CLEAR, ST_DUMP: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   bus        : regfile_mp_if slave port carrying
//                NRD combinational read ports, two write ports (port 1 wins),
//                clear/dump requests, busy and the registered dump stream.
// Parameters: WIDTH data bits, AW address bits (DEPTH = 2**AW), NRD read
// ports, ZERO_REG hardwires entry 0 to zero, BYPASS forwards same-cycle write
// data to matching reads while the sweep engine is idle.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  sweep_state_e  state;
  logic [AW-1:0] idx;
  logic          busy;

  rf_sweep_ctrl #(.AW(AW)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .dump_req (bus.dump_req),
    .state    (state),
    .idx      (idx),
    .busy     (busy)
  );

  // User writes are accepted only while the engine is idle; entry 0 is
  // read-only when ZERO_REG is set.
  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = bus.we0 && (state == ST_IDLE) && !((ZERO_REG != 0) && (bus.wa0 == '0));
  assign wr1_ok = bus.we1 && (state == ST_IDLE) && !((ZERO_REG != 0) && (bus.wa1 == '0));

  // Port 1 is assigned last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_CLEAR) begin
      mem[idx] <= '0;
    end else begin
      if (wr0_ok) mem[bus.wa0] <= bus.wd0;
      if (wr1_ok) mem[bus.wa1] <= bus.wd1;
    end
  end

  // Read ports: stored value, optionally bypassed, zero register last.
  logic [NRD*WIDTH-1:0] rd_flat;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;

    assign a = bus.ra[g*AW +: AW];

    always_comb begin
      v = mem[a];
      if ((BYPASS != 0) && !busy) begin
        if (bus.we1 && (bus.wa1 == a))      v = bus.wd1;
        else if (bus.we0 && (bus.wa0 == a)) v = bus.wd0;
      end
      if ((ZERO_REG != 0) && (a == '0)) v = '0;
    end

    assign rd_flat[g*WIDTH +: WIDTH] = v;
  end

  assign bus.rd = rd_flat;

  // ---- stage p1: registered dump stream, one cycle behind the engine ----
  logic             vld_p1;
  logic [AW-1:0]    dump_addr_p1;
  logic [WIDTH-1:0] dump_data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      dump_addr_p1 <= '0;
      dump_data_p1 <= '0;
    end else begin
      vld_p1 <= (state == ST_DUMP);
      if (state == ST_DUMP) begin
        dump_addr_p1 <= idx;
        dump_data_p1 <= ((ZERO_REG != 0) && (idx == '0)) ? '0 : mem[idx];
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.dump_valid = vld_p1;
  assign bus.dump_addr  = dump_addr_p1;
  assign bus.dump_data  = dump_data_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp.
// Instance u_a: WIDTH=32 AW=5 NRD=2 ZERO_REG=1 BYPASS=1.
// Instance u_b: WIDTH=16 AW=3 NRD=4 ZERO_REG=1 BYPASS=1.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_regfile_mp;

  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 8;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NRD(2)) ifa ();
  regfile_mp_if #(.WIDTH(16), .AW(3), .NRD(4)) ifb ();

  regfile_mp #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regfile_mp #(.WIDTH(16), .AW(3), .NRD(4), .ZERO_REG(1), .BYPASS(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_a [DEPTH_A];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_a(input logic [4:0] a, input logic [31:0] d);
    ifa.we0 = 1'b1;
    ifa.wa0 = a;
    ifa.wd0 = d;
    @(negedge clk);
    ifa.we0 = 1'b0;
    if (a != 5'd0) model_a[a] = d;
  endtask

  // Starts a sweep on u_a (dump, or clear+dump together which must clear)
  // and watches DEPTH_A+4 samples. With inject set, a write to entry 9 is
  // attempted mid-sweep and must be neither bypassed nor stored.
  task automatic sweep_a(input bit is_dump, input bit inject);
    int busy_cnt;
    int vld_cnt;
    int bad;
    busy_cnt = 0;
    vld_cnt  = 0;
    bad      = 0;
    ifa.dump_req = 1'b1;
    ifa.clr_req  = !is_dump;
    @(negedge clk);
    ifa.dump_req = 1'b0;
    ifa.clr_req  = 1'b0;
    for (int s = 0; s < DEPTH_A + 4; s++) begin
      if (ifa.busy) busy_cnt++;
      if (s == 0) begin
        check("sweep_start_busy", 64'(ifa.busy), 64'd1);
        check("sweep_start_vld", 64'(ifa.dump_valid), 64'd0);
      end
      if (ifa.dump_valid) begin
        vld_cnt++;
        if (s == 0 || s > DEPTH_A) bad++;
        else if (ifa.dump_addr !== 5'(s - 1) || ifa.dump_data !== model_a[s-1]) bad++;
      end
      if (s == DEPTH_A + 1) check("sweep_vld_after", 64'(ifa.dump_valid), 64'd0);
      if (inject && s == 20) begin
        ifa.we0 = 1'b1;
        ifa.wa0 = 5'd9;
        ifa.wd0 = 32'd555;
        ifa.ra[4:0] = 5'd9;
        #1;
        check("busy_no_bypass", 64'(ifa.rd[31:0]), 64'd0);
      end
      if (inject && s == 22) ifa.we0 = 1'b0;
      @(negedge clk);
    end
    check("sweep_busy_cycles", 64'(busy_cnt), 64'd32);
    check("sweep_vld_cycles", 64'(vld_cnt), is_dump ? 64'd32 : 64'd0);
    check("sweep_data", 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt [8];

  initial begin
    int bad;
    rst_n = 1'b0;
    ifa.ra = '0; ifa.we0 = 1'b0; ifa.wa0 = '0; ifa.wd0 = '0;
    ifa.we1 = 1'b0; ifa.wa1 = '0; ifa.wd1 = '0;
    ifa.clr_req = 1'b0; ifa.dump_req = 1'b0;
    ifb.ra = '0; ifb.we0 = 1'b0; ifb.wa0 = '0; ifb.wd0 = '0;
    ifb.we1 = 1'b0; ifb.wa1 = '0; ifb.wd1 = '0;
    ifb.clr_req = 1'b0; ifb.dump_req = 1'b0;
    for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;

    //                we0   wa0    wd0      we1   wa1    wd1      ra0    ra1    e0       e1
    vt[0] = '{1'b1, 5'd0, 32'd123, 1'b1, 5'd1, 32'd456, 5'd0, 5'd1, 32'd0,  32'd456};
    vt[1] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   5'd0, 5'd1, 32'd0,  32'd456};
    vt[2] = '{1'b1, 5'd5, 32'd10,  1'b1, 5'd5, 32'd20,  5'd5, 5'd1, 32'd20, 32'd456};
    vt[3] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   5'd5, 5'd5, 32'd20, 32'd20};
    vt[4] = '{1'b1, 5'd7, 32'd77,  1'b0, 5'd0, 32'd0,   5'd7, 5'd5, 32'd77, 32'd20};
    vt[5] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   5'd7, 5'd0, 32'd77, 32'd0};
    vt[6] = '{1'b1, 5'd8, 32'd88,  1'b1, 5'd7, 32'd99,  5'd8, 5'd7, 32'd88, 32'd99};
    vt[7] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   5'd8, 5'd7, 32'd88, 32'd99};

    // Reset state, while reset is held and after release.
    repeat (2) @(negedge clk);
    ifa.ra = {5'd4, 5'd3};
    #1;
    check("rst_busy", 64'(ifa.busy), 64'd0);
    check("rst_dump_valid", 64'(ifa.dump_valid), 64'd0);
    check("rst_dump_addr", 64'(ifa.dump_addr), 64'd0);
    check("rst_dump_data", 64'(ifa.dump_data), 64'd0);
    check("rst_rd", 64'(ifa.rd), 64'd0);
    check("rst_busy_b", 64'(ifb.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read/write/bypass/priority/zero-register vectors.
    for (int i = 0; i < 8; i++) begin
      ifa.we0 = vt[i].we0; ifa.wa0 = vt[i].wa0; ifa.wd0 = vt[i].wd0;
      ifa.we1 = vt[i].we1; ifa.wa1 = vt[i].wa1; ifa.wd1 = vt[i].wd1;
      ifa.ra  = {vt[i].ra1, vt[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), 64'(ifa.rd[31:0]), 64'(vt[i].e0));
      check($sformatf("vec%0d_rd1", i), 64'(ifa.rd[63:32]), 64'(vt[i].e1));
      if (vt[i].we0 && vt[i].wa0 != 5'd0) model_a[vt[i].wa0] = vt[i].wd0;
      if (vt[i].we1 && vt[i].wa1 != 5'd0) model_a[vt[i].wa1] = vt[i].wd1;
      @(negedge clk);
    end
    ifa.we0 = 1'b0;
    ifa.we1 = 1'b0;

    // Fill r1..r31 with i*3 and dump everything.
    for (int i = 1; i < DEPTH_A; i++) write_a(5'(i), 32'(i * 3));
    sweep_a(1'b1, 1'b0);

    // Clear and dump requested together: clear only, mid-sweep write dropped.
    sweep_a(1'b0, 1'b1);
    for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;
    bad = 0;
    for (int i = 0; i < DEPTH_A; i++) begin
      ifa.ra[4:0] = 5'(i);
      #1;
      if (ifa.rd[31:0] !== 32'd0) bad++;
    end
    check("clear_all_zero", 64'(bad), 64'd0);
    @(negedge clk);

    // Reset in the middle of a dump.
    write_a(5'd2, 32'd22);
    write_a(5'd9, 32'd99);
    write_a(5'd31, 32'd31);
    ifa.dump_req = 1'b1;
    @(negedge clk);
    ifa.dump_req = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_pre_vld", 64'(ifa.dump_valid), 64'd1);
    check("abort_pre_addr", 64'(ifa.dump_addr), 64'd9);
    check("abort_pre_data", 64'(ifa.dump_data), 64'd99);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(ifa.busy), 64'd0);
    check("abort_vld", 64'(ifa.dump_valid), 64'd0);
    check("abort_addr", 64'(ifa.dump_addr), 64'd0);
    check("abort_data", 64'(ifa.dump_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH_A; i++) model_a[i] = '0;
    bad = 0;
    for (int i = 0; i < DEPTH_A; i++) begin
      ifa.ra[4:0] = 5'(i);
      #1;
      if (ifa.rd[31:0] !== 32'd0) bad++;
    end
    check("abort_all_zero", 64'(bad), 64'd0);
    @(negedge clk);
    check("abort_idle", 64'(ifa.busy), 64'd0);
    write_a(5'd3, 32'h33);
    write_a(5'd30, 32'h3030);
    sweep_a(1'b1, 1'b0);

    // Narrow build: four read ports and an 8-entry dump.
    for (int i = 1; i < DEPTH_B; i++) begin
      ifb.we1 = 1'b1;
      ifb.wa1 = 3'(i);
      ifb.wd1 = 16'(16'h1000 + i * 17);
      @(negedge clk);
    end
    ifb.we1 = 1'b0;
    ifb.ra = {3'd7, 3'd5, 3'd0, 3'd3};
    #1;
    check("b_rd0", 64'(ifb.rd[15:0]), 64'h1033);
    check("b_rd1", 64'(ifb.rd[31:16]), 64'h0);
    check("b_rd2", 64'(ifb.rd[47:32]), 64'h1055);
    check("b_rd3", 64'(ifb.rd[63:48]), 64'h1077);
    @(negedge clk);
    begin
      int busy_cnt;
      int vld_cnt;
      busy_cnt = 0;
      vld_cnt  = 0;
      bad      = 0;
      ifb.dump_req = 1'b1;
      @(negedge clk);
      ifb.dump_req = 1'b0;
      for (int s = 0; s < DEPTH_B + 4; s++) begin
        if (ifb.busy) busy_cnt++;
        if (ifb.dump_valid) begin
          vld_cnt++;
          if (s == 0 || s > DEPTH_B) bad++;
          else if (ifb.dump_addr !== 3'(s - 1) ||
                   ifb.dump_data !== ((s == 1) ? 16'h0 : 16'(16'h1000 + (s - 1) * 17))) bad++;
        end
        @(negedge clk);
      end
      check("b_busy_cycles", 64'(busy_cnt), 64'd8);
      check("b_vld_cycles", 64'(vld_cnt), 64'd8);
      check("b_dump_data", 64'(bad), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
